// File: rtl/video_sig_gen.sv
// Raster timing generator: horizontal/vertical counters plus sync, active-draw,
// new-frame pulse and frame counter, all registered and aligned to the same pixel.
module video_sig_gen #(
    parameter int ACTIVE_H = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int ACTIVE_V = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter int FPS      = 60,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        en_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        hs_out,
    output logic        vs_out,
    output logic        ad_out,
    output logic        nf_out,
    output logic [5:0]  fc_out
);

    localparam int H_TOTAL = ACTIVE_H + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = ACTIVE_V + V_FP + V_SYNC + V_BP;

    // The counters are 11/10 bits wide and the frame counter 6 bits wide.
    if (H_TOTAL > 2048 || V_TOTAL > 1024 || FPS < 1 || FPS > 64) begin : g_param_check
        $error("video_sig_gen: timing parameters exceed counter widths");
    end

    // Inclusive upper bounds keep every compare at counter width even when a
    // range ends exactly at the total.
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_ACT_LAST = 11'(ACTIVE_H - 1);
    localparam logic [10:0] HS_FIRST   = 11'(ACTIVE_H + H_FP);
    localparam logic [10:0] HS_LAST    = 11'(ACTIVE_H + H_FP + H_SYNC - 1);
    localparam logic [10:0] H_NF       = 11'(ACTIVE_H);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(ACTIVE_V - 1);
    localparam logic [9:0]  VS_FIRST   = 10'(ACTIVE_V + V_FP);
    localparam logic [9:0]  VS_LAST    = 10'(ACTIVE_V + V_FP + V_SYNC - 1);
    localparam logic [9:0]  V_NF       = 10'(ACTIVE_V);
    localparam logic [5:0]  FC_LAST    = 6'(FPS - 1);

    logic        h_wrap;
    logic [10:0] h_next;
    logic [9:0]  v_next;
    logic        hs_next;
    logic        vs_next;
    logic        ad_next;
    logic        nf_next;
    logic [5:0]  fc_next;

    // Next raster position and the flags describing that position.
    always_comb begin
        h_wrap  = 1'b0;
        h_next  = hcount_out;
        v_next  = vcount_out;
        hs_next = ~SYNC_POL;
        vs_next = ~SYNC_POL;
        ad_next = 1'b0;
        nf_next = 1'b0;
        fc_next = fc_out;

        h_wrap = (hcount_out == H_LAST);
        if (h_wrap) begin
            h_next = 11'd0;
            if (vcount_out == V_LAST) begin
                v_next = 10'd0;
            end else begin
                v_next = vcount_out + 10'd1;
            end
        end else begin
            h_next = hcount_out + 11'd1;
        end

        if (h_next >= HS_FIRST && h_next <= HS_LAST) begin
            hs_next = SYNC_POL;
        end
        if (v_next >= VS_FIRST && v_next <= VS_LAST) begin
            vs_next = SYNC_POL;
        end
        ad_next = (h_next <= H_ACT_LAST) && (v_next <= V_ACT_LAST);
        nf_next = (h_next == H_NF) && (v_next == V_NF);

        if (nf_next) begin
            if (fc_out == FC_LAST) begin
                fc_next = 6'd0;
            end else begin
                fc_next = fc_out + 6'd1;
            end
        end
    end

    // Output registers; reset parks the raster on the last pixel of a frame so
    // the first enabled edge lands on (0,0). A stall holds everything but nf.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_out <= H_LAST;
            vcount_out <= V_LAST;
            hs_out     <= ~SYNC_POL;
            vs_out     <= ~SYNC_POL;
            ad_out     <= 1'b0;
            nf_out     <= 1'b0;
            fc_out     <= 6'd0;
        end else if (en_in) begin
            hcount_out <= h_next;
            vcount_out <= v_next;
            hs_out     <= hs_next;
            vs_out     <= vs_next;
            ad_out     <= ad_next;
            nf_out     <= nf_next;
            fc_out     <= fc_next;
        end else begin
            nf_out     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen using a reduced raster: 8x6 active, 16x10 total, FPS=4.
// hs on h=10..12, vs on lines 7..8, nf at (8,6), frame = 160 cycles.
module tb_video_sig_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic        hs;
    logic        vs;
    logic        ad;
    logic        nf;
    logic [5:0]  fc;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    int   mh;
    int   mv;
    int   mfc;
    logic mnf;

    localparam logic [30:0] RESET_VEC = {11'd15, 10'd9, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0};
    localparam logic [30:0] START_VEC = {11'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd0};

    video_sig_gen #(
        .ACTIVE_H(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .ACTIVE_V(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .FPS(4), .SYNC_POL(1'b1)
    ) dut (
        .clk_in    (clk),
        .rst_n_in  (rst_n),
        .en_in     (en),
        .hcount_out(hcount),
        .vcount_out(vcount),
        .hs_out    (hs),
        .vs_out    (vs),
        .ad_out    (ad),
        .nf_out    (nf),
        .fc_out    (fc)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] act_vec();
        return {hcount, vcount, hs, vs, ad, nf, fc};
    endfunction

    function automatic logic [30:0] exp_vec();
        logic e_hs, e_vs, e_ad;
        e_hs = (mh >= 10 && mh <= 12);
        e_vs = (mv >= 7 && mv <= 8);
        e_ad = (mh < 8 && mv < 6);
        return {11'(mh), 10'(mv), e_hs, e_vs, e_ad, mnf, 6'(mfc)};
    endfunction

    task automatic model_reset();
        mh = 15; mv = 9; mfc = 0; mnf = 1'b0;
    endtask

    task automatic model_step(input logic e);
        mnf = 1'b0;
        if (e) begin
            if (mh == 15) begin
                mh = 0;
                mv = (mv == 9) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            if (mh == 8 && mv == 6) begin
                mnf = 1'b1;
                mfc = (mfc == 3) ? 0 : mfc + 1;
            end
        end
    endtask

    // One clock: drive en, let the edge happen, sample 1 time unit later.
    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        model_step(e);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        en    = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_async: got %h want %h", act_vec(), RESET_VEC);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if (act_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL reset_hold: got %h want %h", act_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        cyc = 0;
    endtask

    task automatic test_first_line();
        int hs_cnt;
        int hs_first;
        hs_cnt   = 0;
        hs_first = -1;
        tick(1'b1);
        n_cmp++;
        if (act_vec() !== START_VEC) begin
            n_bad++;
            $display("FAIL first_edge: got %h want %h", act_vec(), START_VEC);
        end
        for (int c = 2; c <= 17; c++) begin
            tick(1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL first_line cyc %0d: got %h want %h", cyc, act_vec(), exp_vec());
            end
            if (c <= 16 && hs === 1'b1) begin
                if (hs_first < 0) hs_first = int'(hcount);
                hs_cnt++;
            end
        end
        n_cmp++;
        if (hcount !== 11'd0 || vcount !== 10'd1) begin
            n_bad++;
            $display("FAIL line_wrap: got h=%0d v=%0d want h=0 v=1", hcount, vcount);
        end
        n_cmp++;
        if (hs_cnt !== 3 || hs_first !== 10) begin
            n_bad++;
            $display("FAIL hs_width: got cnt=%0d start=%0d want cnt=3 start=10", hs_cnt, hs_first);
        end
    endtask

    task automatic test_frame();
        int nf_cyc;
        int nf_cnt;
        int vs_cnt;
        nf_cyc = -1;
        nf_cnt = 0;
        vs_cnt = 0;
        while (cyc < 170) begin
            tick(1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL frame cyc %0d: got %h want %h", cyc, act_vec(), exp_vec());
            end
            if (nf === 1'b1) begin
                nf_cnt++;
                if (nf_cyc < 0) nf_cyc = cyc;
            end
            if (vs === 1'b1) vs_cnt++;
        end
        n_cmp++;
        if (nf_cyc !== 105 || nf_cnt !== 1) begin
            n_bad++;
            $display("FAIL first_nf: got cyc=%0d cnt=%0d want cyc=105 cnt=1", nf_cyc, nf_cnt);
        end
        n_cmp++;
        if (vs_cnt !== 32) begin
            n_bad++;
            $display("FAIL vs_width: got %0d want 32", vs_cnt);
        end
        n_cmp++;
        if (fc !== 6'd1) begin
            n_bad++;
            $display("FAIL fc_after_frame: got %0d want 1", fc);
        end
    endtask

    task automatic test_fc_wrap();
        int last_nf;
        int pulses;
        int bad_period;
        int fc_at_585;
        last_nf    = 105;
        pulses     = 0;
        bad_period = 0;
        fc_at_585  = -1;
        while (cyc < 760) begin
            tick(1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL fc_run cyc %0d: got %h want %h", cyc, act_vec(), exp_vec());
            end
            if (nf === 1'b1) begin
                pulses++;
                if (cyc - last_nf != 160) bad_period++;
                last_nf = cyc;
                if (cyc == 585) fc_at_585 = int'(fc);
            end
        end
        n_cmp++;
        if (pulses !== 4 || bad_period !== 0) begin
            n_bad++;
            $display("FAIL frame_period: got pulses=%0d bad_periods=%0d want 4/0", pulses, bad_period);
        end
        n_cmp++;
        if (fc_at_585 !== 0) begin
            n_bad++;
            $display("FAIL fc_wrap: got %0d want 0", fc_at_585);
        end
    endtask

    task automatic test_random_en();
        logic e;
        logic prev_nf;
        int   forced;
        int   nf_bad;
        prev_nf = 1'b0;
        forced  = 0;
        nf_bad  = 0;
        for (int i = 0; i < 600; i++) begin
            e = ($urandom_range(0, 9) >= 3);
            if (mh == 7 && mv == 6 && forced < 2) begin
                e = 1'b0;
                forced++;
            end
            tick(e);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL random_en step %0d en=%0b: got %h want %h", i, e, act_vec(), exp_vec());
            end
            if ((nf === 1'b1 && !e) || (nf === 1'b1 && prev_nf)) nf_bad++;
            prev_nf = nf;
        end
        n_cmp++;
        if (nf_bad !== 0) begin
            n_bad++;
            $display("FAIL nf_stall: got %0d bad pulses want 0", nf_bad);
        end
    endtask

    task automatic test_mid_reset();
        int guard;
        guard = 0;
        while (!(mh == 5 && mv == 3) && guard < 400) begin
            tick(1'b1);
            guard++;
        end
        n_cmp++;
        if (hcount !== 11'd5 || vcount !== 10'd3) begin
            n_bad++;
            $display("FAIL mid_position: got h=%0d v=%0d want h=5 v=3", hcount, vcount);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (act_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL mid_reset_async: got %h want %h", act_vec(), RESET_VEC);
        end
        en = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (act_vec() !== RESET_VEC) begin
            n_bad++;
            $display("FAIL mid_reset_hold: got %h want %h", act_vec(), RESET_VEC);
        end
        rst_n = 1'b1;
        model_reset();
        tick(1'b1);
        n_cmp++;
        if (act_vec() !== START_VEC) begin
            n_bad++;
            $display("FAIL restart: got %h want %h", act_vec(), START_VEC);
        end
        for (int i = 0; i < 120; i++) begin
            tick(1'b1);
            n_cmp++;
            if (act_vec() !== exp_vec()) begin
                n_bad++;
                $display("FAIL restart_run step %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_frame();
        test_fc_wrap();
        test_random_en();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
